// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmit state encoding plus common command
// and reply byte values used by the transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_DONE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins, plus a falling-edge
// strobe on the synchronized clock. Lines reset to their idle (high) level.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic fall_o
);

  logic [1:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic       clk_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  assign clk_s_o = clk_sync_q[1];
  assign dat_s_o = dat_sync_q[1];
  assign fall_o  = clk_prev_q & ~clk_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pull-low enables.
// Define PS2_TX_TIMEOUT_EN to build in the request-to-send -> done watchdog.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned INHIBIT_US  = 120,
  parameter int unsigned TIMEOUT_MS  = 15
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int unsigned INHIBIT_CYCLES = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  localparam int          INH_W          = $clog2(INHIBIT_CYCLES);

  if (TIMEOUT_MS == 0 || INHIBIT_US < 100) begin : g_param_check
    $error("ps2_host_tx: INHIBIT_US must be >= 100 and TIMEOUT_MS nonzero");
  end

  ps2_tx_state_t state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [3:0]       bit_q, bit_d;
  logic             nack_q, nack_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic [9:0]       frame_q;
  logic             load, shift;
  logic             clk_s, dat_s, fall;

  ps2_line_sync u_sync (
    .clk_i    (CLOCK_50),
    .rst_ni   (reset),
    .ps2_clk_i(PS2_CLK),
    .ps2_dat_i(PS2_DAT),
    .clk_s_o  (clk_s),
    .dat_s_o  (dat_s),
    .fall_o   (fall)
  );

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ_HZ / 1000 * TIMEOUT_MS;
  localparam int          TO_W           = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  always_comb begin
    state_d  = state_q;
    inh_d    = inh_q;
    bit_d    = bit_q;
    nack_d   = nack_q;
    clk_oe_d = 1'b0;
    dat_oe_d = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d  = ST_INHIBIT;
          clk_oe_d = 1'b1;
          inh_d    = '0;
          nack_d   = 1'b0;
          load     = 1'b1;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (inh_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          state_d  = ST_RTS;
          dat_oe_d = 1'b1;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      ST_RTS: begin
        // Start bit stays on the data line while the device takes over the clock.
        state_d  = ST_SEND;
        dat_oe_d = 1'b1;
        bit_d    = '0;
      end
      ST_SEND: begin
        dat_oe_d = dat_oe_q;
        if (fall) begin
          dat_oe_d = ~frame_q[0];
          shift    = 1'b1;
          if (bit_q == 4'd9) state_d = ST_ACK;
          else               bit_d   = bit_q + 1'b1;
        end
      end
      ST_ACK: begin
        if (fall) begin
          nack_d  = dat_s;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && dat_s) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Counts cycles since RTS; a value of N means N cycles have elapsed.
    to_d = '0;
    if (state_q == ST_RTS) begin
      to_d = TO_W'(1);
    end else if (state_q == ST_SEND || state_q == ST_ACK || state_q == ST_WAIT_IDLE) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        state_d  = ST_DONE;
        nack_d   = 1'b1;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        shift    = 1'b0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      inh_q    <= '0;
      bit_q    <= '0;
      nack_q   <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      inh_q    <= inh_d;
      bit_q    <= bit_d;
      nack_q   <= nack_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
`ifdef PS2_TX_TIMEOUT_EN
      to_q     <= to_d;
`endif
    end
  end

  // Frame is {stop, odd parity, data}, shifted out LSB first.
  always_ff @(posedge CLOCK_50) begin
    if (load)       frame_q <= {1'b1, ~^tx_data, tx_data};
    else if (shift) frame_q <= {1'b0, frame_q[9:1]};
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = done & nack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host, and a queue of expected frames is checked on every done pulse.
module tb_ps2_host_tx;

  localparam int H           = 20;  // device clock half period, system cycles
  localparam int TB_TO_MS    = 1;
  localparam int TB_TO_CYC   = 50_000_000 / 1000 * TB_TO_MS;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic       PS2_CLK, PS2_DAT;
  logic       ps2_clk_oe, ps2_dat_oe;

  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       dev_en      = 1'b1;
  logic       dev_ack     = 1'b1;
  logic       dev_active  = 1'b0;
  int         dev_bit     = 0;
  logic [9:0] rx_bits     = '0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       par;
    logic       err;
  } vec_t;
  vec_t vecs[4];

  assign PS2_CLK = ~(ps2_clk_oe | dev_clk_low);
  assign PS2_DAT = ~(ps2_dat_oe | dev_dat_low);

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .CLK_FREQ_HZ(50_000_000),
    .INHIBIT_US (120),
    .TIMEOUT_MS (TB_TO_MS)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe)
  );

  // Device: after request-to-send, clocks 10 bits in (sampled on the rising
  // clock), then pulls DAT low across the 11th clock when acknowledging.
  initial begin : device
    forever begin
      @(negedge ps2_clk_oe);
      @(negedge CLOCK_50);
      if (dev_en && ps2_dat_oe) begin
        dev_active = 1'b1;
        rx_bits    = '0;
        repeat (10) @(negedge CLOCK_50);
        for (int i = 0; i < 10; i++) begin
          dev_bit     = i;
          dev_clk_low = 1'b1;
          repeat (H) @(negedge CLOCK_50);
          dev_clk_low = 1'b0;
          repeat (H) @(negedge CLOCK_50);
          rx_bits[i] = PS2_DAT;
        end
        dev_bit     = 10;
        dev_dat_low = dev_ack;
        repeat (5) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge CLOCK_50);
        dev_clk_low = 1'b0;
        repeat (H) @(negedge CLOCK_50);
        dev_dat_low = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        dev_active = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic par, input logic e, input logic push);
    int n;
    n = 0;
    @(negedge CLOCK_50);
    while ((dev_active || !tx_ready) && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("ready_before_send", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    if (push) sb.push_back('{data: d, par: par, err: e});
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
  endtask

  task automatic finish_xfer(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 30000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_data"}, {24'd0, rx_bits[7:0]}, {24'd0, e.data});
      chk({tag, "_parity"}, {31'd0, rx_bits[8]}, {31'd0, e.par});
      chk({tag, "_stop"}, {31'd0, rx_bits[9]}, 32'd1);
      chk({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
    end
    @(negedge CLOCK_50);
    chk({tag, "_done_pulse_len"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_after_done"}, {31'd0, tx_ready}, 32'd1);
  endtask

  initial begin : main
    int n;
    int ok;
    vecs[0] = '{data: 8'hED, ack: 1'b1, par: 1'b1, err: 1'b0};
    vecs[1] = '{data: 8'hFF, ack: 1'b0, par: 1'b1, err: 1'b1};
    vecs[2] = '{data: 8'h01, ack: 1'b1, par: 1'b0, err: 1'b0};
    vecs[3] = '{data: 8'hA5, ack: 1'b1, par: 1'b1, err: 1'b0};

    repeat (3) @(negedge CLOCK_50);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 4; i++) begin
      dev_ack = vecs[i].ack;
      send(vecs[i].data, vecs[i].par, vecs[i].err, 1'b1);
      chk("busy_during_xfer", {30'd0, busy, tx_ready}, 32'd2);
      finish_xfer($sformatf("vec%0d", i));
    end

    // Inhibit/RTS timing with 0x00; sample 1 is the cycle after accept.
    dev_ack = 1'b1;
    send(8'h00, 1'b1, 1'b0, 1'b1);
    ok = 0;
    for (int k = 0; k < 6000; k++) begin
      if (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0) ok++;
      @(negedge CLOCK_50);
    end
    chk("inhibit_cycles", ok, 32'd6000);
    chk("rts_both_low", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
    @(negedge CLOCK_50);
    chk("send_clk_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
    finish_xfer("inhibit0");

    // Reset during SEND: lines released at once, no done afterwards.
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (dev_bit < 3 && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("reached_send", {31'd0, (dev_bit >= 3)}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("midrst_ready", {30'd0, tx_ready, busy}, 32'd2);
    @(negedge CLOCK_50);
    reset = 1'b1;
    ok = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge CLOCK_50);
      if (done !== 1'b0) ok++;
    end
    chk("midrst_no_done", ok, 32'd0);
    chk("midrst_ready_after", {31'd0, tx_ready}, 32'd1);

    // Back-to-back: valid held while busy, data changed after accept.
    dev_ack = 1'b1;
    n = 0;
    while (dev_active && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    sb.push_back('{data: 8'h3C, par: 1'b1, err: 1'b0});
    @(negedge CLOCK_50);
    tx_data = 8'h80;
    sb.push_back('{data: 8'h80, par: 1'b0, err: 1'b0});
    chk("b2b_busy_ignores", {30'd0, busy, tx_ready}, 32'd2);
    finish_xfer("b2b_first");
    @(negedge CLOCK_50);
    chk("b2b_second_accepted", {31'd0, busy}, 32'd1);
    tx_valid = 1'b0;
    finish_xfer("b2b_second");

`ifdef PS2_TX_TIMEOUT_EN
    // Silent device: watchdog ends the transfer a fixed time after RTS.
    dev_en = 1'b0;
    send(8'hED, 1'b1, 1'b1, 1'b0);
    n = 0;
    while (!(ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1) && n < 7000) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("to_rts_seen", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
    n = 0;
    while (done !== 1'b1 && n < TB_TO_CYC + 100) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("to_cycles", n, TB_TO_CYC);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_oe_released", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    dev_en = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
